// File: rtl/demo_de0_sys_irq_ctrl.sv
// Avalon-MM interrupt controller: synchronises up to 16 sources, latches them per level/edge mode,
// masks with ENABLE and drives one registered irq; one-clock registered read latency, no wait states.
module demo_de0_sys_irq_ctrl #(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic [15:0]        readdata,
  output logic               irq
);

  localparam logic [15:0] SRC_MASK = 16'((17'd1 << NUM_SRC) - 17'd1);

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_PENDING = 3'd1;
  localparam logic [2:0] ADDR_ENABLE  = 3'd2;
  localparam logic [2:0] ADDR_MODE    = 3'd3;
  localparam logic [2:0] ADDR_ACTIVE  = 3'd4;
  localparam logic [2:0] ADDR_VECTOR  = 3'd5;
  localparam logic [2:0] ADDR_SET     = 3'd6;

  // Registers are kept 16 bits wide; bits at and above NUM_SRC are held at zero.
  logic [15:0] r_sync [SYNC_STAGES];
  logic [15:0] r_prev;
  logic [15:0] r_pending;
  logic [15:0] r_enable;
  logic [15:0] r_mode;
  logic [15:0] r_readdata;
  logic        r_irq;

  logic [15:0] w_sync;
  logic [15:0] w_rise;
  logic        w_wr;
  logic [15:0] w_wd;
  logic [15:0] w_set;
  logic [15:0] w_clr;
  logic [15:0] w_mode_chg;
  logic [15:0] w_pend_edge;
  logic [15:0] w_pend_nxt;
  logic [15:0] w_active;
  logic [3:0]  w_vec_idx;
  logic [15:0] w_vector;
  logic [15:0] w_rd_mux;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_rise = w_sync & ~r_prev;
  assign w_wr   = chipselect & ~write_n;
  assign w_wd   = writedata & SRC_MASK;

  assign w_set      = (w_wr && address == ADDR_SET)     ? w_wd : 16'd0;
  assign w_clr      = (w_wr && address == ADDR_PENDING) ? w_wd : 16'd0;
  assign w_mode_chg = (w_wr && address == ADDR_MODE)    ? (w_wd ^ r_mode) : 16'd0;

  // Edge bits: set beats clear; level bits track sync; a mode flip clears regardless.
  assign w_pend_edge = (r_pending & ~w_clr) | w_rise | w_set;
  assign w_pend_nxt  = ((r_mode & w_pend_edge) | (~r_mode & w_sync)) & ~w_mode_chg & SRC_MASK;

  assign w_active = r_pending & r_enable;

  always_comb begin
    w_vec_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (w_active[i]) w_vec_idx = 4'(i);
    end
  end

  assign w_vector = {|w_active, 11'd0, w_vec_idx};

  always_comb begin
    w_rd_mux = 16'd0;
    case (address)
      ADDR_STATUS:  w_rd_mux = w_sync;
      ADDR_PENDING: w_rd_mux = r_pending;
      ADDR_ENABLE:  w_rd_mux = r_enable;
      ADDR_MODE:    w_rd_mux = r_mode;
      ADDR_ACTIVE:  w_rd_mux = w_active;
      ADDR_VECTOR:  w_rd_mux = w_vector;
      default:      w_rd_mux = 16'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= 16'd0;
    end else begin
      r_sync[0] <= 16'(irq_src);
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev     <= 16'd0;
      r_pending  <= 16'd0;
      r_enable   <= 16'd0;
      r_mode     <= 16'd0;
      r_readdata <= 16'd0;
      r_irq      <= 1'b0;
    end else begin
      r_prev     <= w_sync;
      r_pending  <= w_pend_nxt;
      r_readdata <= w_rd_mux;
      r_irq      <= |w_active;
      if (w_wr && address == ADDR_ENABLE) r_enable <= w_wd;
      if (w_wr && address == ADDR_MODE)   r_mode   <= w_wd;
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;

endmodule

// File: tb/tb_demo_de0_sys_irq_ctrl.sv
// Scoreboard bench: stimulus pushes expected read/irq values; a monitor pops and compares them.
module tb_demo_de0_sys_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = 16'd0;
  logic [7:0]  irq_src = 8'd0;
  logic [15:0] readdata;
  logic        irq;

  demo_de0_sys_irq_ctrl #(.NUM_SRC(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .irq_src(irq_src),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  logic [15:0] rd_exp_q[$];
  string       rd_name_q[$];
  logic        irq_exp_q[$];
  string       irq_name_q[$];
  logic        rd_req = 1'b0, rd_vld = 1'b0;
  logic        irq_req = 1'b0, irq_vld = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(posedge clk) begin
    rd_vld  <= rd_req;
    irq_vld <= irq_req;
  end

  // Monitor: compares at the negedge following the posedge that produced the output.
  always @(negedge clk) begin
    if (rd_vld) begin
      if (rd_exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rd_underflow: read valid with empty scoreboard");
      end else begin
        logic [15:0] e;
        string nm;
        e  = rd_exp_q.pop_front();
        nm = rd_name_q.pop_front();
        n_cmp++;
        if (readdata !== e) begin
          n_bad++;
          $display("FAIL %s: readdata=0x%04h expected 0x%04h", nm, readdata, e);
        end
      end
    end
    if (irq_vld) begin
      if (irq_exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL irq_underflow: irq check with empty scoreboard");
      end else begin
        logic e;
        string nm;
        e  = irq_exp_q.pop_front();
        nm = irq_name_q.pop_front();
        n_cmp++;
        if (irq !== e) begin
          n_bad++;
          $display("FAIL %s: irq=%0b expected %0b", nm, irq, e);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] e, input string nm);
    address = a;
    rd_exp_q.push_back(e);
    rd_name_q.push_back(nm);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  // Arms an irq check for the next posedge without consuming a cycle.
  task automatic arm_irq(input logic e, input string nm);
    irq_exp_q.push_back(e);
    irq_name_q.push_back(nm);
    irq_req = 1'b1;
  endtask

  task automatic chk_irq(input logic e, input string nm);
    arm_irq(e, nm);
    @(negedge clk);
    irq_req = 1'b0;
  endtask

  initial begin
    idle(3);
    reset_n = 1'b1;
    rd(3'd0, 16'h0000, "init_status");
    chk_irq(1'b0, "init_irq");

    // Level path: irq follows src 4 clocks later in both directions.
    wr(3'd2, 16'h0001);
    irq_src[0] = 1'b1;
    idle(2);
    chk_irq(1'b0, "lvl_rise_early");
    chk_irq(1'b1, "lvl_rise_exact");
    rd(3'd5, 16'h8000, "lvl_vector");
    rd(3'd0, 16'h0001, "lvl_status");
    irq_src[0] = 1'b0;
    idle(2);
    chk_irq(1'b1, "lvl_fall_early");
    chk_irq(1'b0, "lvl_fall_exact");

    // Edge latch survives the pulse; W1C clears it.
    wr(3'd3, 16'h0004);
    wr(3'd2, 16'h0004);
    irq_src[2] = 1'b1;
    idle(3);
    irq_src[2] = 1'b0;
    idle(4);
    rd(3'd1, 16'h0004, "edge_pending");
    chk_irq(1'b1, "edge_irq");
    rd(3'd5, 16'h8002, "edge_vector");
    arm_irq(1'b1, "w1c_irq_hold");
    wr(3'd1, 16'h0004);
    chk_irq(1'b0, "w1c_irq_clear");
    rd(3'd1, 16'h0000, "w1c_pending");

    // Priority and mask.
    wr(3'd3, 16'h00FF);
    wr(3'd2, 16'h00F0);
    wr(3'd6, 16'h0028);
    rd(3'd1, 16'h0028, "prio_pending");
    rd(3'd4, 16'h0020, "prio_active");
    rd(3'd5, 16'h8005, "prio_vector");
    chk_irq(1'b1, "prio_irq");
    arm_irq(1'b1, "mask_irq_hold");
    wr(3'd2, 16'h0000);
    chk_irq(1'b0, "mask_irq_clear");
    rd(3'd1, 16'h0028, "mask_pending");

    // Rise of bit1 coincides with its W1C write: set wins.
    irq_src[1] = 1'b1;
    idle(2);
    wr(3'd1, 16'h0002);
    rd(3'd1, 16'h002A, "setclr_pending");
    irq_src[1] = 1'b0;
    idle(3);
    wr(3'd3, 16'h00FD);
    rd(3'd1, 16'h0028, "modechg_pending");
    wr(3'd6, 16'h0002);
    rd(3'd1, 16'h0028, "set_level_ignored");

    // Width bounds.
    wr(3'd2, 16'hFFFF);
    wr(3'd3, 16'hFFFF);
    wr(3'd6, 16'hFFFF);
    rd(3'd2, 16'h00FF, "wid_enable");
    rd(3'd3, 16'h00FF, "wid_mode");
    rd(3'd1, 16'h00FF, "wid_pending");
    rd(3'd4, 16'h00FF, "wid_active");
    rd(3'd5, 16'h8000, "wid_vector");
    rd(3'd6, 16'h0000, "wid_set_read");
    rd(3'd7, 16'h0000, "wid_reserved");
    chk_irq(1'b1, "wid_irq");

    // Reset mid-operation with pending=0x00FF.
    reset_n = 1'b0;
    rd(3'd1, 16'h0000, "rst_readdata");
    chk_irq(1'b0, "rst_irq");
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) rd(3'(a), 16'h0000, $sformatf("post_rst_addr%0d", a));
    repeat (5) chk_irq(1'b0, "post_rst_idle_irq");

    for (int t = 0; t < 20 && (rd_exp_q.size() != 0 || irq_exp_q.size() != 0); t++)
      @(negedge clk);
    if (rd_exp_q.size() != 0 || irq_exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d reads and %0d irq checks left, expected 0",
               rd_exp_q.size(), irq_exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/demo_de0_sys_irq_ctrl.md
Name: demo_de0_sys_irq_ctrl

Overview:
Avalon-MM interrupt controller directly downstream of the system's interval timer(s) and other peripheral irq lines. Collects up to 16 interrupt sources and synchronises them. Latches each source per a software-selected mode (level or rising edge), applies an enable mask, and drives one registered irq to the CPU. Software reads a prioritised vector to find the lowest-numbered active source.

Parameters:
NUM_SRC, 8, number of interrupt sources (legal 1..16); register bits at and above NUM_SRC read 0 and ignore writes
SYNC_STAGES, 2, flip-flop depth of the input synchroniser per source (legal 2..3)

Ports:
clk  input  1  system clock
reset_n  input  1  reset; one clock; reset is asynchronous and active-low
address  input  3  register word select
chipselect  input  1  slave select
write_n  input  1  active-low write strobe; write occurs when chipselect=1 and write_n=0
writedata  input  16  write data
irq_src  input  NUM_SRC  raw source lines, active high, may be asynchronous to clk
readdata  output  16  registered read data
irq  output  1  registered CPU interrupt request, active high

Behaviour:
- Reset (async, reset_n=0): all synchroniser flops, prev-sample flops, pending, enable, mode, readdata, irq = 0.
- Synchroniser: each irq_src bit passes SYNC_STAGES flops giving sync[i]. prev[i] <= sync[i] every clock.
- Edge detect: rise[i] = sync[i] & ~prev[i]. prev resets to 0, so a source held high through reset release yields one rise event.
- Pending, per bit, registered, one clock after cause:
  - mode[i]=0 (level): pending[i] <= sync[i]. W1C and SET writes have no effect.
  - mode[i]=1 (edge): set on rise[i] or a SET write bit. Clear on PENDING write-1 bit. Set wins if set and clear coincide in one clock.
  - A MODE write that changes mode[i] forces pending[i] <= 0 on that clock, overriding all other causes.
- active = pending & enable. irq <= |active (registered).
- Latency from a stable irq_src edge: irq asserts SYNC_STAGES+2 clocks later in both modes. An ENABLE write affects irq 1 clock after the write clock.
- Register map (address, access, content):
  - 0 RO STATUS = sync
  - 1 RW1C PENDING = pending
  - 2 RW ENABLE
  - 3 RW MODE (1=edge)
  - 4 RO ACTIVE = active
  - 5 RO VECTOR: bit15 = |active; bits[3:0] = index of lowest-numbered set bit of active, 0 when none; other bits 0
  - 6 WO SET: write-1 sets edge-mode pending; reads 0
  - 7 reserved: reads 0, writes ignored
- Reads: readdata <= mux(address) on every clock, independent of chipselect, for one-clock read latency. The value reflects register state before any write on the same clock.
- Writes take effect on the clock edge where the write strobe is sampled. Unused writedata bits are ignored.

Test Plan:
- Reset/idle: assert reset_n=0 mid-operation with pending=0x00FF, then release. Required: readdata=0, irq=0, all registers read 0, and irq_src=0 keeps irq=0 indefinitely.
- Level path: MODE=0, ENABLE=0x01; raise irq_src[0] on a clock boundary. Required: irq=1 exactly SYNC_STAGES+2 clocks later; VECTOR reads 0x8000. Drop irq_src[0]: irq=0 after SYNC_STAGES+2 clocks.
- Edge latch and W1C: MODE=0x04, ENABLE=0x04; pulse irq_src[2] high for 3 clocks. Required: PENDING=0x0004 persists after the pulse, irq=1, VECTOR=0x8002. Write PENDING=0x0004: irq=0 one clock after pending clears.
- Priority and mask: MODE=0xFF, ENABLE=0xF0, SET=0x28. Required: PENDING=0x0028, ACTIVE=0x0020, VECTOR=0x8005. Write ENABLE=0x00: irq=0 next clock, PENDING still 0x0028.
- Simultaneous set/clear: edge mode on bit 1; align rise[1] with a PENDING write of 0x0002. Required: PENDING bit1=1 afterward. Then change MODE bit1 to 0 with irq_src[1] low: PENDING bit1=0 on the next clock.
- Width bounds, NUM_SRC=8: write 0xFFFF to ENABLE/MODE/SET. Required: reads return 0x00FF; address 7 reads 0x0000; the SET readback at address 6 is 0x0000.
